// File: rtl/push_button_debouncer.sv
// Synchroniser + debounce FSM for one active-low push button, producing a clean
// level and one-cycle press/release pulses; long_press is built only when
// PUSH_BUTTON_LONG_PRESS_EN is defined (otherwise it is tied low).
module push_button_debouncer #(
  parameter int SYNC_STAGES       = 2,
  parameter int DEBOUNCE_CYCLES   = 12000,
  parameter int LONG_PRESS_CYCLES = 12000000
) (
  input  logic clock,
  input  logic reset,
  input  logic push_button_n,
  output logic push_button,
  output logic pressed,
  output logic released,
  output logic long_press
);

  localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);

  typedef enum logic [1:0] {
    ST_RELEASED    = 2'd0,
    ST_ARM_PRESS   = 2'd1,
    ST_HELD        = 2'd2,
    ST_ARM_RELEASE = 2'd3
  } state_t;

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   sample_s;
  state_t                 state_r;
  state_t                 state_next_s;
  logic [CW-1:0]          cnt_r;
  logic [CW-1:0]          cnt_next_s;
  logic                   level_next_s;
  logic                   pressed_next_s;
  logic                   released_next_s;

  // Metastability chain; reset loads the released (high) pin level.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync_r <= {SYNC_STAGES{1'b1}};
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], push_button_n};
    end
  end

  assign sample_s = ~sync_r[SYNC_STAGES-1];

  // FSM state and debounce counter registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= ST_RELEASED;
      cnt_r   <= CNT_ZERO;
    end else begin
      state_r <= state_next_s;
      cnt_r   <= cnt_next_s;
    end
  end

  // Next-state logic; the counter is cleared on every accept or reject so it never wraps.
  always_comb begin
    state_next_s    = state_r;
    cnt_next_s      = cnt_r;
    level_next_s    = push_button;
    pressed_next_s  = 1'b0;
    released_next_s = 1'b0;
    case (state_r)
      ST_RELEASED: begin
        cnt_next_s   = CNT_ZERO;
        level_next_s = 1'b0;
        if (sample_s) begin
          state_next_s = ST_ARM_PRESS;
        end else begin
          state_next_s = ST_RELEASED;
        end
      end
      ST_ARM_PRESS: begin
        if (!sample_s) begin
          state_next_s = ST_RELEASED;
          cnt_next_s   = CNT_ZERO;
        end else if (cnt_r == CNT_LAST) begin
          state_next_s   = ST_HELD;
          cnt_next_s     = CNT_ZERO;
          level_next_s   = 1'b1;
          pressed_next_s = 1'b1;
        end else begin
          cnt_next_s = cnt_r + CNT_ONE;
        end
      end
      ST_HELD: begin
        cnt_next_s   = CNT_ZERO;
        level_next_s = 1'b1;
        if (!sample_s) begin
          state_next_s = ST_ARM_RELEASE;
        end else begin
          state_next_s = ST_HELD;
        end
      end
      ST_ARM_RELEASE: begin
        if (sample_s) begin
          state_next_s = ST_HELD;
          cnt_next_s   = CNT_ZERO;
        end else if (cnt_r == CNT_LAST) begin
          state_next_s    = ST_RELEASED;
          cnt_next_s      = CNT_ZERO;
          level_next_s    = 1'b0;
          released_next_s = 1'b1;
        end else begin
          cnt_next_s = cnt_r + CNT_ONE;
        end
      end
      default: begin
        state_next_s = ST_RELEASED;
        cnt_next_s   = CNT_ZERO;
        level_next_s = 1'b0;
      end
    endcase
  end

  // Registered level and event pulses.
  always_ff @(posedge clock) begin
    if (reset) begin
      push_button <= 1'b0;
      pressed     <= 1'b0;
      released    <= 1'b0;
    end else begin
      push_button <= level_next_s;
      pressed     <= pressed_next_s;
      released    <= released_next_s;
    end
  end

`ifdef PUSH_BUTTON_LONG_PRESS_EN
  localparam int HW = (LONG_PRESS_CYCLES > 2) ? $clog2(LONG_PRESS_CYCLES) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_PRESS_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_FIRE = HW'(LONG_PRESS_CYCLES - 2);
  localparam logic [HW-1:0] HOLD_ONE  = HW'(1);
  localparam logic [HW-1:0] HOLD_ZERO = HW'(0);

  logic [HW-1:0] hold_r;

  // Hold counter starts at 0 on the press and saturates so only one long_press fires.
  always_ff @(posedge clock) begin
    if (reset) begin
      hold_r     <= HOLD_ZERO;
      long_press <= 1'b0;
    end else if (pressed_next_s || released_next_s) begin
      hold_r     <= HOLD_ZERO;
      long_press <= 1'b0;
    end else if (push_button) begin
      if (hold_r != HOLD_LAST) begin
        hold_r     <= hold_r + HOLD_ONE;
        long_press <= (hold_r == HOLD_FIRE);
      end else begin
        hold_r     <= hold_r;
        long_press <= 1'b0;
      end
    end else begin
      hold_r     <= HOLD_ZERO;
      long_press <= 1'b0;
    end
  end
`else
  assign long_press = 1'b0;
`endif

endmodule

// File: tb/tb_push_button_debouncer.sv
// Scoreboard bench: a per-edge reference model built from run-length rules pushes
// expected outputs; a monitor pops and compares one entry after every clock edge.
module tb_push_button_debouncer;

  localparam int S = 2;
  localparam int D = 4;
  localparam int L = 16;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic push_button_n = 1'b1;
  logic push_button, pressed, released, long_press;

  push_button_debouncer #(
    .SYNC_STAGES(S), .DEBOUNCE_CYCLES(D), .LONG_PRESS_CYCLES(L)
  ) dut (
    .clock(clock), .reset(reset), .push_button_n(push_button_n),
    .push_button(push_button), .pressed(pressed), .released(released),
    .long_press(long_press)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic lvl;
    logic p;
    logic r;
    logic lp;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // reference model state
  logic pin_pipe [S];
  logic m_level = 1'b0;
  int   run = 0;
  int   age = 0;

  task automatic check(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b at t=%0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clock) begin : monitor
    exp_t e;
    #1;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check("push_button", push_button, e.lvl);
      check("pressed", pressed, e.p);
      check("released", released, e.r);
      check("long_press", long_press, e.lp);
    end
  end

  // Drive one cycle of inputs and predict what the next edge registers.
  task automatic step(input logic rst, input logic pin);
    exp_t e;
    logic s;
    @(negedge clock);
    reset = rst;
    push_button_n = pin;
    e.p = 1'b0; e.r = 1'b0; e.lp = 1'b0;
    if (rst) begin
      for (int i = 0; i < S; i++) pin_pipe[i] = 1'b1;
      m_level = 1'b0;
      run = 0;
      age = 0;
    end else begin
      s = ~pin_pipe[S-1];
      for (int i = S-1; i > 0; i--) pin_pipe[i] = pin_pipe[i-1];
      pin_pipe[0] = pin;
      // a change is accepted after D+1 consecutive disagreeing samples
      if (s != m_level) begin
        run++;
        if (run == D + 1) begin
          m_level = s;
          run = 0;
          if (s) e.p = 1'b1;
          else   e.r = 1'b1;
        end
      end else begin
        run = 0;
      end
      if (e.p) begin
        age = 0;
      end else if (m_level) begin
        age++;
`ifdef PUSH_BUTTON_LONG_PRESS_EN
        if (age == L - 1) e.lp = 1'b1;
`endif
      end else begin
        age = 0;
      end
    end
    e.lvl = m_level;
    sb_q.push_back(e);
  endtask

  task automatic hold(input logic rst, input logic pin, input int n);
    for (int i = 0; i < n; i++) step(rst, pin);
  endtask

  initial begin
    int kind;
    int len;
    for (int i = 0; i < S; i++) pin_pipe[i] = 1'b1;

    hold(1'b1, 1'b1, 10);                      // reset, released
    hold(1'b0, 1'b0, 10); hold(1'b0, 1'b1, 10); // clean press / release
    hold(1'b0, 1'b0, 3);  hold(1'b0, 1'b1, 10); // short glitch
    hold(1'b0, 1'b0, 4);  hold(1'b0, 1'b1, 10); // one short of threshold
    hold(1'b0, 1'b0, 5);  hold(1'b0, 1'b1, 12); // exactly threshold
    hold(1'b0, 1'b0, 10); hold(1'b0, 1'b1, 2);  // release glitch while held
    hold(1'b0, 1'b0, 8);  hold(1'b0, 1'b1, 4);  // release one short
    hold(1'b0, 1'b0, 8);  hold(1'b0, 1'b1, 12);
    hold(1'b0, 1'b0, 60); hold(1'b0, 1'b1, 12); // long press, one pulse only
    hold(1'b0, 1'b0, 12); hold(1'b1, 1'b0, 3);  // reset while held
    hold(1'b0, 1'b0, 25); hold(1'b0, 1'b1, 12);

    for (int seg = 0; seg < 150; seg++) begin
      kind = $urandom_range(0, 9);
      if (kind <= 3) begin
        len = $urandom_range(1, 8);
        for (int k = 0; k < len; k++) step(1'b0, 1'($urandom_range(0, 1)));
      end else if (kind <= 6) begin
        hold(1'b0, 1'($urandom_range(0, 1)), $urandom_range(1, 8));
      end else if (kind <= 8) begin
        hold(1'b0, 1'b0, $urandom_range(15, 40));
      end else begin
        hold(1'b1, 1'($urandom_range(0, 1)), $urandom_range(1, 3));
      end
    end
    hold(1'b0, 1'b1, 12);

    repeat (2) @(posedge clock);
    #2;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
